sha256_seq_ctrl: RTL and testbench

- Sequencer between the Tiny Tapeout pin interface and the byte-serial SHA-256 shift-register core.
- Accepts one 64-byte pre-padded message block from the host over a valid/ready byte stream and shifts it into the core.
- Starts the core, waits for completion with a watchdog, then streams the 32-byte digest back out with valid/ready.
- Lets the top level share the 8-bit ui_in/uo_out pins between load and unload phases.

---
 rtl/sha256_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_sha256_seq_ctrl.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_seq_ctrl.sv
// Load/hash/unload sequencer for a byte-serial SHA-256 core: shifts one pre-padded block in,
// starts the core under a watchdog, then streams the digest out over valid/ready.
module sha256_seq_ctrl #(
    parameter int unsigned MSG_BYTES = 64,
    parameter int unsigned DIG_BYTES = 32,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    input  logic       abort_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i,
    output logic       core_clear_o,
    output logic       core_load_o,
    output logic [7:0] core_din_o,
    output logic       core_start_o,
    input  logic       core_done_i,
    input  logic [7:0] core_dout_i,
    output logic       core_unload_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned CntW = $clog2(MSG_BYTES + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] LastMsg = CntW'(MSG_BYTES - 1);
    localparam logic [CntW-1:0] LastDig = CntW'(DIG_BYTES - 1);
    // The watchdog fires on the HASH cycle whose increment would reach TIMEOUT-1.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StHash,
        StUnload
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
        done_d       = 1'b0;
        core_clear_o = 1'b0;
        core_start_o = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ena_i) begin
                    state_d      = StLoad;
                    core_clear_o = 1'b1;
                    err_d        = 1'b0;
                    byte_cnt_d   = '0;
                end
            end
            StLoad: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (byte_cnt_q == LastMsg) begin
                        state_d    = StStart;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                core_start_o = 1'b1;
                tmo_cnt_d    = '0;
                state_d      = StHash;
            end
            StHash: begin
                // A done arriving on the expiry cycle still counts as success.
                if (core_done_i) begin
                    state_d    = StUnload;
                    byte_cnt_d = '0;
                end else if (tmo_cnt_q == TmoLast) begin
                    err_d     = 1'b1;
                    state_d   = StIdle;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StUnload: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (byte_cnt_q == LastDig) begin
                        done_d     = 1'b1;
                        state_d    = StIdle;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort_i) begin
            state_d      = StIdle;
            byte_cnt_d   = '0;
            tmo_cnt_d    = '0;
            done_d       = 1'b0;
            err_d        = err_q;
            core_start_o = 1'b0;
            core_clear_o = (state_q != StIdle);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Data paths are gated so every output idles at zero outside its phase.
    assign core_load_o   = in_valid_i & in_ready_o;
    assign core_din_o    = in_ready_o ? in_data_i : 8'h00;
    assign out_data_o    = out_valid_o ? core_dout_i : 8'h00;
    assign core_unload_o = out_valid_o & out_ready_i;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_sha256_seq_ctrl.sv
// Directed bench for sha256_seq_ctrl with a behavioural core that only yields the "abc"
// digest when exactly the padded "abc" block was shifted in since the last clear.
module tb_sha256_seq_ctrl;

    localparam int unsigned MSG_BYTES = 64;
    localparam int unsigned DIG_BYTES = 32;
    localparam int unsigned TIMEOUT   = 1024;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ena = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, core_clear, core_load, core_start, core_unload;
    logic       busy, done, err, core_done;
    logic [7:0] out_data, core_din, core_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sha256_seq_ctrl #(
        .MSG_BYTES(MSG_BYTES),
        .DIG_BYTES(DIG_BYTES),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ena_i        (ena),
        .abort_i      (abort),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .core_clear_o (core_clear),
        .core_load_o  (core_load),
        .core_din_o   (core_din),
        .core_start_o (core_start),
        .core_done_i  (core_done),
        .core_dout_i  (core_dout),
        .core_unload_o(core_unload),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    // ---------------- core model ----------------
    logic [7:0] msg_mem [MSG_BYTES];
    int   load_cnt, unload_idx, hash_timer;
    int   done_delay = 5;
    logic hashing, dig_ok;
    int   n_load = 0, n_unload = 0, n_start = 0;

    function automatic logic [7:0] blk_byte(input int i);
        case (i)
            0:       return 8'h61;
            1:       return 8'h62;
            2:       return 8'h63;
            3:       return 8'h80;
            63:      return 8'h18;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        return ABC_DIG[255-8*i -: 8];
    endfunction

    function automatic logic msg_is_abc();
        for (int i = 0; i < MSG_BYTES; i++) if (msg_mem[i] !== blk_byte(i)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || core_clear) begin
            load_cnt   <= 0;
            unload_idx <= 0;
            hashing    <= 1'b0;
            hash_timer <= 0;
            dig_ok     <= 1'b0;
        end else begin
            if (core_load) begin
                if (load_cnt < MSG_BYTES) msg_mem[load_cnt] <= core_din;
                load_cnt <= load_cnt + 1;
            end
            if (core_start) begin
                hashing    <= 1'b1;
                hash_timer <= 0;
                unload_idx <= 0;
                dig_ok     <= (load_cnt == MSG_BYTES) && msg_is_abc();
            end else if (hashing) begin
                hash_timer <= hash_timer + 1;
            end
            if (core_unload) unload_idx <= unload_idx + 1;
        end
    end

    always @(posedge clk_i) begin
        if (core_load) n_load <= n_load + 1;
        if (core_unload) n_unload <= n_unload + 1;
        if (core_start) n_start <= n_start + 1;
    end

    assign core_done = hashing && (done_delay >= 0) && (hash_timer == done_delay);

    always_comb begin
        core_dout = 8'hee;
        if (dig_ok && unload_idx < DIG_BYTES) core_dout = exp_byte(unload_idx);
        else core_dout = 8'hee ^ unload_idx[7:0];
    end

    // ---------------- stimulus tasks ----------------
    task automatic start_seq();
        @(negedge clk_i);
        ena = 1'b1;
        #1;
        checks++;
        if (core_clear !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_clear got clear=%b busy=%b exp clear=1 busy=0", core_clear, busy);
        end
    endtask

    // Ends on the negedge of the START cycle.
    task automatic load_block(input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < MSG_BYTES && guard < 2000) begin
            @(negedge clk_i);
            ena      = 1'b0;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = blk_byte(i);
            #1;
            if (in_valid && in_ready) i++;
            guard++;
        end
        checks++;
        if (i != MSG_BYTES) begin
            errors++;
            $display("FAIL load_accept got %0d bytes exp %0d", i, MSG_BYTES);
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        checks++;
        if (core_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse got start=%b ready=%b exp start=1 ready=0",
                     core_start, in_ready);
        end
    endtask

    task automatic unload_block(input int stall_pct, input int nbytes, output int lat);
        int cyc = 0;
        int got = 0;
        int guard = 0;
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        out_ready = 1'b0;
        do begin
            @(negedge clk_i);
            #1;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < TIMEOUT + 50);
        lat = cyc;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL unload_wait got out_valid=%b exp 1 after %0d cycles", out_valid, cyc);
            return;
        end
        while (got < nbytes && guard < 2000) begin
            if (stalled) begin
                checks++;
                if (out_data !== held) begin
                    errors++;
                    $display("FAIL stall_stable got %h exp %h", out_data, held);
                end
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL out_valid_hold got %b exp 1 at byte %0d", out_valid, got);
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            checks++;
            if (core_unload !== out_ready) begin
                errors++;
                $display("FAIL core_unload got %b exp %b", core_unload, out_ready);
            end
            if (out_ready) begin
                checks++;
                if (out_data !== exp_byte(got)) begin
                    errors++;
                    $display("FAIL digest_byte[%0d] got %h exp %h", got, out_data, exp_byte(got));
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = out_data;
            end
            guard++;
            @(negedge clk_i);
            #1;
        end
        out_ready = 1'b0;
        if (nbytes == DIG_BYTES) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got done=%b busy=%b ov=%b exp 1 0 0",
                         done, busy, out_valid);
            end
            @(negedge clk_i);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_width got done=%b exp 0", done);
            end
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, core_clear, core_load, core_din, core_start,
             core_unload, busy, done, err} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero output exp all 0 (busy=%b err=%b)", busy, err);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b ready=%b exp 0 0", busy, in_ready);
        end
    endtask

    task automatic test_abc();
        int lat;
        int l0 = n_load, u0 = n_unload, s0 = n_start;
        done_delay = 5;
        start_seq();
        load_block(0);
        unload_block(0, DIG_BYTES, lat);
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL abc_latency got %0d exp 7", lat);
        end
        checks++;
        if (n_load - l0 != MSG_BYTES || n_unload - u0 != DIG_BYTES || n_start - s0 != 1) begin
            errors++;
            $display("FAIL abc_counts got load=%0d unload=%0d start=%0d exp 64 32 1",
                     n_load - l0, n_unload - u0, n_start - s0);
        end
    endtask

    task automatic test_stalls();
        int lat;
        int l0 = n_load, u0 = n_unload;
        done_delay = 2;
        start_seq();
        load_block(50);
        unload_block(50, DIG_BYTES, lat);
        checks++;
        if (n_load - l0 != MSG_BYTES || n_unload - u0 != DIG_BYTES) begin
            errors++;
            $display("FAIL stall_counts got load=%0d unload=%0d exp 64 32",
                     n_load - l0, n_unload - u0);
        end
    endtask

    task automatic test_timeout();
        int t = 0;
        done_delay = -1;
        start_seq();
        load_block(0);
        do begin
            @(negedge clk_i);
            #1;
            t++;
        end while (err !== 1'b1 && t < 2 * TIMEOUT);
        checks++;
        if (t != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp %0d", t, TIMEOUT);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got busy=%b ov=%b exp 0 0", busy, out_valid);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", err);
        end
        start_seq();
        @(negedge clk_i);
        ena = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%b ready=%b exp 0 1", err, in_ready);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (core_clear !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear_load got %b exp 1", core_clear);
        end
        @(negedge clk_i);
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_abort();
        int lat;
        int starts = 0;
        done_delay = 4;
        @(negedge clk_i);
        ena   = 1'b1;
        abort = 1'b1;
        #1;
        checks++;
        if (core_clear !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_clear got %b exp 0", core_clear);
        end
        @(negedge clk_i);
        ena   = 1'b0;
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_stay got busy=%b exp 0", busy);
        end
        start_seq();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            ena      = 1'b0;
            in_valid = 1'b1;
            in_data  = blk_byte(k);
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        abort    = 1'b1;
        #1;
        checks++;
        if (core_clear !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse got clear=%b busy=%b exp 1 1", core_clear, busy);
        end
        @(negedge clk_i);
        abort = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || core_clear !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got ready=%b busy=%b clear=%b exp 0 0 0",
                     in_ready, busy, core_clear);
        end
        repeat (70) begin
            @(negedge clk_i);
            #1;
            if (core_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL abort_no_start got %0d starts exp 0", starts);
        end
        start_seq();
        load_block(0);
        unload_block(0, DIG_BYTES, lat);
    endtask

    task automatic test_done_timeout_tie();
        int lat;
        done_delay = TIMEOUT - 2;
        start_seq();
        load_block(0);
        unload_block(0, DIG_BYTES, lat);
        checks++;
        if (lat != TIMEOUT) begin
            errors++;
            $display("FAIL tie_latency got %0d exp %0d", lat, TIMEOUT);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL tie_err got %b exp 0", err);
        end
    endtask

    task automatic test_reset_mid_unload();
        int lat;
        int busy_seen = 0;
        done_delay = 3;
        start_seq();
        load_block(0);
        unload_block(0, 5, lat);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_unload_valid got %b exp 1", out_valid);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, core_clear, core_load, core_din, core_start,
             core_unload, busy, done, err} !== 25'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got ov=%b od=%h busy=%b exp all 0",
                     out_valid, out_data, busy);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL post_reset_busy got %0d busy cycles exp 0", busy_seen);
        end
        start_seq();
        load_block(0);
        unload_block(0, DIG_BYTES, lat);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stalls();
        test_timeout();
        test_abort();
        test_done_timeout_tie();
        test_reset_mid_unload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion exp finish within 1 ms");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
